// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue queue: opcodes, default widths and the entry layout.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_MUL = 5'b00011;

    localparam int DEF_TAG_W  = 4;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic                  rdy;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_DATA_W-1:0] data;
    } iq_src_t;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           opcode;
        logic [DEF_TAG_W-1:0] dest_tag;
        iq_src_t              src1;
        iq_src_t              src2;
    } iq_entry_t;

endpackage

// File: rtl/iq_select_lowest.sv
// Combinational priority picker: grants the lowest set bit of req.
module iq_select_lowest #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan downwards so the lowest requesting index is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_issue_queue.sv
// Reservation-style issue queue ahead of the ALU: holds ops until both operands
// arrive (directly or via CDB) and issues the lowest-index ready op each cycle.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dispatch_valid,
    output logic                       dispatch_ready,
    input  logic [4:0]                 dispatch_opcode,
    input  logic [TAG_W-1:0]           dispatch_dest_tag,
    input  logic                       dispatch_src1_rdy,
    input  logic [TAG_W-1:0]           dispatch_src1_tag,
    input  logic [DATA_W-1:0]          dispatch_src1_data,
    input  logic                       dispatch_src2_rdy,
    input  logic [TAG_W-1:0]           dispatch_src2_tag,
    input  logic [DATA_W-1:0]          dispatch_src2_data,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       issue_valid,
    output logic [4:0]                 issue_opcode,
    output logic [DATA_W-1:0]          issue_src1_data,
    output logic [DATA_W-1:0]          issue_src2_data,
    output logic [TAG_W-1:0]           issue_dest_tag,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = IW + 1;

    // Local entry layout so non-default widths still work.
    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } src_t;

    typedef struct packed {
        logic             valid;
        logic [4:0]       opcode;
        logic [TAG_W-1:0] dest_tag;
        src_t             src1;
        src_t             src2;
    } entry_t;

    entry_t             entries [DEPTH];
    entry_t             disp_entry;
    logic [DEPTH-1:0]   eligible;
    logic [DEPTH-1:0]   free_vec;
    logic [IW-1:0]      sel_idx;
    logic [IW-1:0]      free_idx;
    logic               sel_any;
    logic               free_any;
    logic               disp_fire;

    for (genvar g = 0; g < DEPTH; g++) begin : g_vec
        assign eligible[g] = entries[g].valid && entries[g].src1.rdy && entries[g].src2.rdy;
        assign free_vec[g] = ~entries[g].valid;
    end

    iq_select_lowest #(.N(DEPTH)) u_sel (
        .req (eligible),
        .idx (sel_idx),
        .any (sel_any)
    );

    // Allocation looks at registered valids, so a slot freed by this cycle's issue is not reused yet.
    iq_select_lowest #(.N(DEPTH)) u_alloc (
        .req (free_vec),
        .idx (free_idx),
        .any (free_any)
    );

    assign dispatch_ready = free_any;
    assign disp_fire      = dispatch_valid && free_any;

    // Same-cycle CDB bypass so a dispatching op never misses its wakeup.
    always_comb begin
        disp_entry           = '0;
        disp_entry.valid     = 1'b1;
        disp_entry.opcode    = dispatch_opcode;
        disp_entry.dest_tag  = dispatch_dest_tag;
        disp_entry.src1.tag  = dispatch_src1_tag;
        disp_entry.src1.rdy  = dispatch_src1_rdy;
        disp_entry.src1.data = dispatch_src1_data;
        disp_entry.src2.tag  = dispatch_src2_tag;
        disp_entry.src2.rdy  = dispatch_src2_rdy;
        disp_entry.src2.data = dispatch_src2_data;
        if (!dispatch_src1_rdy && cdb_valid && dispatch_src1_tag == cdb_tag) begin
            disp_entry.src1.rdy  = 1'b1;
            disp_entry.src1.data = cdb_data;
        end
        if (!dispatch_src2_rdy && cdb_valid && dispatch_src2_tag == cdb_tag) begin
            disp_entry.src2.rdy  = 1'b1;
            disp_entry.src2.data = cdb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            issue_valid     <= 1'b0;
            issue_opcode    <= '0;
            issue_src1_data <= '0;
            issue_src2_data <= '0;
            issue_dest_tag  <= '0;
            occupancy       <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].valid && cdb_valid) begin
                    if (!entries[i].src1.rdy && entries[i].src1.tag == cdb_tag) begin
                        entries[i].src1.rdy  <= 1'b1;
                        entries[i].src1.data <= cdb_data;
                    end
                    if (!entries[i].src2.rdy && entries[i].src2.tag == cdb_tag) begin
                        entries[i].src2.rdy  <= 1'b1;
                        entries[i].src2.data <= cdb_data;
                    end
                end
            end
            issue_valid <= sel_any;
            if (sel_any) begin
                entries[sel_idx].valid <= 1'b0;
                issue_opcode           <= entries[sel_idx].opcode;
                issue_src1_data        <= entries[sel_idx].src1.data;
                issue_src2_data        <= entries[sel_idx].src2.data;
                issue_dest_tag         <= entries[sel_idx].dest_tag;
            end
            if (disp_fire) entries[free_idx] <= disp_entry;
            occupancy <= occupancy + OW'(disp_fire) - OW'(sel_any);
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed plus randomized bench for alu_issue_queue against a slot-array reference model.
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_valid, dispatch_ready;
    logic [4:0]  dispatch_opcode;
    logic [3:0]  dispatch_dest_tag, dispatch_src1_tag, dispatch_src2_tag;
    logic        dispatch_src1_rdy, dispatch_src2_rdy;
    logic [31:0] dispatch_src1_data, dispatch_src2_data;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issue_valid;
    logic [4:0]  issue_opcode;
    logic [31:0] issue_src1_data, issue_src2_data;
    logic [3:0]  issue_dest_tag;
    logic [2:0]  occupancy;

    int n_cmp = 0;
    int n_err = 0;

    iq_entry_t   m [DEPTH];
    logic        e_iv;
    logic [4:0]  e_op;
    logic [31:0] e_s1, e_s2;
    logic [3:0]  e_dt;
    int          e_occ;

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_opcode(dispatch_opcode), .dispatch_dest_tag(dispatch_dest_tag),
        .dispatch_src1_rdy(dispatch_src1_rdy), .dispatch_src1_tag(dispatch_src1_tag),
        .dispatch_src1_data(dispatch_src1_data),
        .dispatch_src2_rdy(dispatch_src2_rdy), .dispatch_src2_tag(dispatch_src2_tag),
        .dispatch_src2_data(dispatch_src2_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_src1_data(issue_src1_data), .issue_src2_data(issue_src2_data),
        .issue_dest_tag(issue_dest_tag), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        e_iv = 0; e_op = 0; e_s1 = 0; e_s2 = 0; e_dt = 0; e_occ = 0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ":issue_valid"}, 64'(issue_valid), 64'(e_iv));
        chk({where, ":opcode"}, 64'(issue_opcode), 64'(e_op));
        chk({where, ":src1"}, 64'(issue_src1_data), 64'(e_s1));
        chk({where, ":src2"}, 64'(issue_src2_data), 64'(e_s2));
        chk({where, ":dest_tag"}, 64'(issue_dest_tag), 64'(e_dt));
        chk({where, ":occupancy"}, 64'(occupancy), 64'(e_occ));
    endtask

    // One clock: predict from current model + inputs, advance, compare after the edge.
    task automatic tick(input string where);
        iq_entry_t nx [DEPTH];
        iq_entry_t ne;
        int sel = -1;
        int fr  = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel < 0 && m[i].valid && m[i].src1.rdy && m[i].src2.rdy) sel = i;
            if (fr < 0 && !m[i].valid) fr = i;
        end
        chk({where, ":dispatch_ready"}, 64'(dispatch_ready), 64'(fr >= 0));
        nx = m;
        for (int i = 0; i < DEPTH; i++) begin
            if (nx[i].valid && cdb_valid) begin
                if (!nx[i].src1.rdy && nx[i].src1.tag == cdb_tag) begin
                    nx[i].src1.rdy = 1; nx[i].src1.data = cdb_data;
                end
                if (!nx[i].src2.rdy && nx[i].src2.tag == cdb_tag) begin
                    nx[i].src2.rdy = 1; nx[i].src2.data = cdb_data;
                end
            end
        end
        e_iv = (sel >= 0);
        if (sel >= 0) begin
            e_op = m[sel].opcode; e_s1 = m[sel].src1.data;
            e_s2 = m[sel].src2.data; e_dt = m[sel].dest_tag;
            nx[sel].valid = 0;
        end
        if (dispatch_valid && fr >= 0) begin
            ne.valid = 1; ne.opcode = dispatch_opcode; ne.dest_tag = dispatch_dest_tag;
            ne.src1 = '{dispatch_src1_rdy, dispatch_src1_tag, dispatch_src1_data};
            ne.src2 = '{dispatch_src2_rdy, dispatch_src2_tag, dispatch_src2_data};
            if (!ne.src1.rdy && cdb_valid && ne.src1.tag == cdb_tag) ne.src1 = '{1'b1, ne.src1.tag, cdb_data};
            if (!ne.src2.rdy && cdb_valid && ne.src2.tag == cdb_tag) ne.src2 = '{1'b1, ne.src2.tag, cdb_data};
            nx[fr] = ne;
        end
        e_occ = 0;
        for (int i = 0; i < DEPTH; i++) if (nx[i].valid) e_occ++;
        @(posedge clk);
        #1;
        m = nx;
        check_outputs(where);
        @(negedge clk);
    endtask

    task automatic idle();
        dispatch_valid = 0;
        cdb_valid      = 0;
    endtask

    task automatic disp(input logic [4:0] op, input logic [3:0] dt,
                        input logic r1, input logic [3:0] t1, input logic [31:0] d1,
                        input logic r2, input logic [3:0] t2, input logic [31:0] d2);
        dispatch_valid = 1; dispatch_opcode = op; dispatch_dest_tag = dt;
        dispatch_src1_rdy = r1; dispatch_src1_tag = t1; dispatch_src1_data = d1;
        dispatch_src2_rdy = r2; dispatch_src2_tag = t2; dispatch_src2_data = d2;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] d);
        cdb_valid = 1; cdb_tag = t; cdb_data = d;
    endtask

    initial begin
        reset = 1;
        idle();
        disp(5'd0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
        dispatch_valid = 0;
        cdb_tag = 0; cdb_data = 0;
        model_reset();
        @(negedge clk);
        check_outputs("reset");
        chk("reset:dispatch_ready", 64'(dispatch_ready), 64'd1);
        reset = 0;

        // Fully ready ADD: issues two edges after dispatch.
        disp(OP_ADD, 4'd2, 1, 4'd0, 32'd5, 1, 4'd0, 32'd7);
        tick("add_w");
        idle();
        tick("add_i");
        chk("add:issue_valid", 64'(issue_valid), 64'd1);
        chk("add:src1", 64'(issue_src1_data), 64'd5);
        chk("add:src2", 64'(issue_src2_data), 64'd7);
        chk("add:occupancy", 64'(occupancy), 64'd0);

        // SUB waiting on tag 3, woken by the CDB.
        disp(OP_SUB, 4'd4, 0, 4'd3, 32'd0, 1, 4'd0, 32'd10);
        tick("sub_w");
        idle();
        for (int k = 0; k < 3; k++) tick("sub_hold");
        chk("sub:no_issue", 64'(issue_valid), 64'd0);
        cdb(4'd3, 32'd20);
        tick("sub_wake");
        chk("sub:not_same_edge", 64'(issue_valid), 64'd0);
        idle();
        tick("sub_i");
        chk("sub:src1", 64'(issue_src1_data), 64'd20);
        chk("sub:src2", 64'(issue_src2_data), 64'd10);

        // Dispatch/CDB bypass.
        disp(OP_MUL, 4'd5, 1, 4'd0, 32'd1, 0, 4'd6, 32'd0);
        cdb(4'd6, 32'hAA);
        tick("byp_w");
        idle();
        tick("byp_i");
        chk("byp:src2", 64'(issue_src2_data), 64'hAA);

        // Fill, drop when full, then drain in index order.
        for (int k = 0; k < 4; k++) begin
            disp(OP_ADD, 4'(8 + k), 0, 4'd1, 32'd0, 1, 4'd0, 32'(k));
            tick("fill");
        end
        chk("full:dispatch_ready", 64'(dispatch_ready), 64'd0);
        disp(OP_SUB, 4'd15, 1, 4'd0, 32'd0, 1, 4'd0, 32'd0);
        tick("full_drop");
        chk("full:occupancy", 64'(occupancy), 64'd4);
        idle();
        cdb(4'd1, 32'h55);
        tick("full_wake");
        idle();
        for (int k = 0; k < 4; k++) begin
            tick("drain");
            chk("drain:order", 64'(issue_dest_tag), 64'(8 + k));
        end

        // Entries 0 and 2 ready together; dispatch alongside issue.
        disp(OP_ADD, 4'd1, 0, 4'd5, 32'd0, 1, 4'd0, 32'd1); tick("pri0");
        disp(OP_ADD, 4'd2, 0, 4'd6, 32'd0, 1, 4'd0, 32'd2); tick("pri1");
        disp(OP_ADD, 4'd3, 0, 4'd5, 32'd0, 1, 4'd0, 32'd3); tick("pri2");
        idle();
        cdb(4'd5, 32'd9);
        tick("pri_wake");
        idle();
        disp(OP_SUB, 4'd7, 1, 4'd0, 32'd4, 1, 4'd0, 32'd4);
        tick("pri_i0");
        chk("pri:first", 64'(issue_dest_tag), 64'd1);
        chk("pri:occ_same", 64'(occupancy), 64'd3);
        idle();
        tick("pri_i2");
        chk("pri:second", 64'(issue_dest_tag), 64'd3);
        tick("pri_i3");
        cdb(4'd6, 32'd0);
        tick("pri_wake6");
        idle();
        for (int k = 0; k < 2; k++) tick("pri_tail");

        // Reset with three queued and an issue in flight.
        for (int k = 0; k < 3; k++) begin
            disp(OP_ADD, 4'(k), 0, 4'd7, 32'd0, 1, 4'd0, 32'd0);
            tick("rst_fill");
        end
        disp(OP_MUL, 4'd9, 1, 4'd0, 32'd3, 1, 4'd0, 32'd3);
        tick("rst_rdy");
        idle();
        tick("rst_iss");
        chk("rst:pre_valid", 64'(issue_valid), 64'd1);
        chk("rst:pre_occ", 64'(occupancy), 64'd3);
        reset = 1;
        #1;
        model_reset();
        check_outputs("rst_async");
        chk("rst:dispatch_ready", 64'(dispatch_ready), 64'd1);
        @(negedge clk);
        reset = 0;
        cdb(4'd7, 32'd1);
        tick("post_rst");
        idle();
        for (int k = 0; k < 2; k++) tick("post_rst_idle");

        // Randomized traffic over a small tag space to force collisions.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) != 0)
                disp(5'($urandom_range(1, 3)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom,
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom);
            else
                dispatch_valid = 0;
            if ($urandom_range(0, 1) != 0) cdb(4'($urandom_range(0, 3)), $urandom);
            else cdb_valid = 0;
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Reservation-style issue queue that sits directly upstream of the ALU execution unit.
- Accepts dispatched ALU ops whose operands may still be pending on producer tags.
- Captures results broadcast on the common data bus (CDB).
- Issues one fully-ready op per cycle; the registered issue outputs drive the ALU's execute_valid, opcode, src1_data and src2_data.

Parameters:
- DEPTH, 4, number of queue entries (power of 2, 2..16)
- TAG_W, 4, width of producer/destination tags
- DATA_W, 32, operand width (must match the ALU)

Ports:
- clk  in  1  clock
- reset  in  1  reset
- dispatch_valid  in  1  new op presented this cycle
- dispatch_ready  out  1  queue can accept an op (at least one free entry)
- dispatch_opcode  in  5  ALU opcode
- dispatch_dest_tag  in  TAG_W  tag of the result this op will produce
- dispatch_src1_rdy  in  1  src1 data already valid
- dispatch_src1_tag  in  TAG_W  src1 producer tag (used when not ready)
- dispatch_src1_data  in  DATA_W  src1 value (used when ready)
- dispatch_src2_rdy / _tag / _data  in  1 / TAG_W / DATA_W  same for src2
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  DATA_W  broadcast value
- issue_valid  out  1  to ALU execute_valid
- issue_opcode  out  5  to ALU opcode
- issue_src1_data  out  DATA_W  to ALU src1_data
- issue_src2_data  out  DATA_W  to ALU src2_data
- issue_dest_tag  out  TAG_W  tag travelling with the issued op
- occupancy  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk.
  - Clears every entry valid bit.
  - issue_valid=0; issue_opcode, issue_src*_data and issue_dest_tag =0; occupancy=0.
  - dispatch_ready=1 one cycle after reset deasserts, or immediately after assertion since it is combinational.
  - Reset mid-operation discards all queued ops; no issue follows.
- Entry fields: valid, opcode, dest_tag, and per source {rdy, tag, data}.
- dispatch_ready = OR of ~valid across entries (combinational). It does not count an entry freed by the same-cycle issue.
- Dispatch fires when dispatch_valid && dispatch_ready.
  - The op is written to the lowest-index free entry.
  - If dispatch_valid is asserted while full, the op is ignored; no state change.
- Wakeup:
  - When cdb_valid, every valid entry with src rdy=0 and src tag==cdb_tag sets rdy=1 and data=cdb_data on that edge.
  - Both sources of the same entry may wake on the same broadcast.
- Dispatch/CDB bypass: if a dispatching op has src_rdy=0 and its tag equals cdb_tag while cdb_valid, it is stored with rdy=1 and data=cdb_data. No lost wakeup.
- Select:
  - An entry is eligible when valid && src1.rdy && src2.rdy, evaluated on registered state.
  - Among eligible entries, the lowest index wins.
  - An entry woken in cycle N is first eligible in cycle N+1.
- Issue: on the edge where an entry is selected:
  - Its fields are copied into the issue_* registers and issue_valid is set to 1.
  - The entry's valid bit is cleared.
  - Latency: from dispatch of a fully-ready op to issue_valid high is 2 edges (write, then select).
  - If no entry is eligible, issue_valid=0 and the other issue_* outputs hold their last values.
  - At most one issue per cycle. The ALU accepts every cycle, so there is no stall input.
- Simultaneous dispatch and issue: both occur. The freed entry is not reused in the same cycle.
- Occupancy is updated each edge as +dispatch_fire −issue_fire.
- The CDB tag width is compared exactly; tag 0 is not special.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=5'b00001, OP_SUB=5'b00010, OP_MUL=5'b00011
  - default TAG_W and DATA_W
  - the entry struct typedef (iq_entry_t)
- One sub-module is natural: iq_select_lowest, a combinational priority picker taking a DEPTH-bit eligible vector and returning a grant index plus any_valid. It is reused for free-slot allocation, taking ~valid as input.

Test Plan:
- Dispatch ADD with src1=5 and src2=7, both ready → two edges later issue_valid=1, opcode 00001, src1 5, src2 7; occupancy returns to 0.
- Dispatch SUB with src1 tag 3 pending and src2=10 ready; hold for 3 cycles → no issue. CDB tag 3 data 20 → issue one cycle later with src1 20, src2 10.
- Dispatch an op whose src2 tag 6 is pending in the same cycle as CDB tag 6 data 0xAA → stored ready; issues next cycle with src2 0xAA.
- Fill 4 entries, all pending on tag 1 → dispatch_ready=0. A fifth dispatch is dropped (occupancy stays 4). CDB tag 1 → four consecutive issues in index order 0,1,2,3.
- Entries 0 and 2 ready at once → entry 0 issues first, entry 2 the next cycle. Dispatch in the same cycle as an issue succeeds; occupancy stays unchanged.
- Assert reset while 3 entries are queued and issue_valid=1 → all outputs 0 immediately; no issue after release.
